// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_DONE} arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_AUX = 1'b1;

  localparam int unsigned DEF_TIMEOUT = 255;

endpackage

// File: rtl/arb_timeout.sv
// Loadable up-counter with clear and enable. Flags the increment that reaches TIMEOUT.
module arb_timeout
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  localparam int unsigned CW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          hit
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // hit is the cycle whose enabled increment would bring the count to TIMEOUT
  assign hit = en && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU and an auxiliary master.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ack,
  output logic          r0_err,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic          r1_err,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          owner
);

  arb_state_e    state_q, state_d;
  logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          owner_q, owner_d, last_q, last_d, busy_q, busy_d;
  logic          r0_ack_q, r0_ack_d, r0_err_q, r0_err_d;
  logic          r1_ack_q, r1_ack_d, r1_err_q, r1_err_d;
  logic [DW-1:0] r0_rdata_q, r0_rdata_d, r1_rdata_q, r1_rdata_d;
  logic          win, tmo_clr, tmo_en, tmo_hit;

  arb_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr),
    .load    (1'b0),
    .load_val('0),
    .en      (tmo_en),
    .hit     (tmo_hit)
  );

  always_comb begin
    state_d     = state_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    owner_d     = owner_q;
    last_d      = last_q;
    r0_ack_d    = 1'b0;
    r0_err_d    = 1'b0;
    r1_ack_d    = 1'b0;
    r1_err_d    = 1'b0;
    r0_rdata_d  = r0_rdata_q;
    r1_rdata_d  = r1_rdata_q;
    tmo_clr     = 1'b0;
    tmo_en      = 1'b0;
    // On a tie the requester that did not go last wins
    win         = (r0_req && r1_req) ? ~last_q : r1_req;

    unique case (state_q)
      ARB_IDLE: begin
        if (r0_req || r1_req) begin
          state_d  = ARB_ACCESS;
          mem_en_d = 1'b1;
          owner_d  = win;
          last_d   = win;
          tmo_clr  = 1'b1;
          if (win == OWN_AUX) begin
            mem_we_d    = r1_we;
            mem_addr_d  = r1_addr;
            mem_wdata_d = r1_wdata;
          end else begin
            mem_we_d    = r0_we;
            mem_addr_d  = r0_addr;
            mem_wdata_d = r0_wdata;
          end
        end
      end
      ARB_ACCESS: begin
        tmo_en = !mem_ready;
        if (mem_ready || tmo_hit) begin
          state_d  = ARB_DONE;
          mem_en_d = 1'b0;
          if (owner_q == OWN_CPU) begin
            r0_ack_d = 1'b1;
            r0_err_d = !mem_ready;
            if (mem_ready && !mem_we_q) r0_rdata_d = mem_rdata;
          end else begin
            r1_ack_d = 1'b1;
            r1_err_d = !mem_ready;
            if (mem_ready && !mem_we_q) r1_rdata_d = mem_rdata;
          end
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase

    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      owner_q     <= OWN_CPU;
      last_q      <= OWN_AUX;
      busy_q      <= 1'b0;
      r0_ack_q    <= 1'b0;
      r0_err_q    <= 1'b0;
      r1_ack_q    <= 1'b0;
      r1_err_q    <= 1'b0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      r0_ack_q    <= r0_ack_d;
      r0_err_q    <= r0_err_d;
      r1_ack_q    <= r1_ack_d;
      r1_err_q    <= r1_err_d;
      r0_rdata_q  <= r0_rdata_d;
      r1_rdata_q  <= r1_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign r0_ack    = r0_ack_q;
  assign r0_err    = r0_err_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_ack    = r1_ack_q;
  assign r1_err    = r1_err_q;
  assign r1_rdata  = r1_rdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port 16-bit memory between the CPU (requester 0) and a second bus master such as a program loader or debug port (requester 1). It sits between the masters and `memory`. It grants one request at a time with round-robin fairness and drives the memory strobe until `mem_ready` returns. It returns read data with a one-cycle acknowledge, and aborts with an error if the memory never answers.

## Interface
- `AW`, 16, address width
- `DW`, 16, data width
- `TIMEOUT`, 255, maximum cycles in ACCESS before abort (≥1); counter width is `$clog2(TIMEOUT+1)`
- `clk` in 1: single clock, all logic on the rising edge
- `rst_n` in 1: reset, synchronous and active-low
- `r0_req`, `r1_req` in 1: access request, held high until the matching ack
- `r0_we`, `r1_we` in 1: 1 = write, 0 = read
- `r0_addr`, `r1_addr` in AW: request address
- `r0_wdata`, `r1_wdata` in DW: write data
- `r0_ack`, `r1_ack` out 1: one-cycle completion pulse
- `r0_err`, `r1_err` out 1: valid with ack; 1 = timed out
- `r0_rdata`, `r1_rdata` out DW: read data, valid from the ack cycle and held until that requester's next ack
- `mem_en` out 1: memory access strobe
- `mem_we` out 1: memory write enable, qualified by `mem_en`
- `mem_addr` out AW: memory address
- `mem_wdata` out DW: memory write data
- `mem_rdata` in DW: memory read data
- `mem_ready` in 1: memory completion, sampled only while `mem_en`=1
- `busy` out 1: high in ACCESS and DONE
- `owner` out 1: requester currently or last granted

## Operation
- FSM has three states: IDLE, ACCESS, DONE.
- **IDLE → ACCESS** when any request is high.
  - Winner selection: if only one request is high, that requester wins. If both are high, the winner is the requester that is not `last`.
  - On entry, register the winner's we/addr/wdata into the `mem_*` outputs, set `owner`/`last` to the winner, set `mem_en`=1, and clear the timeout counter.
- **ACCESS**: `mem_*` outputs stay constant. The counter increments each cycle while `mem_ready`=0.
  - `mem_ready`=1 → DONE. Capture `mem_rdata` into the owner's rdata register on reads only; writes leave rdata unchanged. Set owner ack=1, err=0, and `mem_en`=0.
  - Counter reaches `TIMEOUT` with no ready → DONE. Set owner ack=1, err=1, `mem_en`=0, and leave rdata unchanged.
  - If `mem_ready` and timeout occur in the same cycle, ready wins.
- **DONE → IDLE** unconditionally. ack and err return to 0.
- **Request rules**
  - A requester holding `req` through its ack cycle and into IDLE issues a new request.
  - If the other requester is also pending at that point, the other requester wins.
  - Request changes during ACCESS are ignored, including deassertion: the access completes and the ack still pulses.
- **Reset values** (`rst_n`=0 at any edge, including mid-ACCESS):
  - State = IDLE.
  - `mem_en`, `mem_we`, both ack, both err, `busy` = 0.
  - `mem_addr`, `mem_wdata`, both rdata = 0.
  - `owner` = 0; `last` = 1, so requester 0 wins the first tie.
  - An access aborted by reset produces no ack.

## Timing
- Req sampled high in IDLE at edge E0 → `mem_en`=1 after E0.
- `mem_ready` sampled at edge E1 → ack=1 for the cycle after E1 → IDLE after E2.
- Minimum latency: 2 cycles from request sample to ack. Throughput: one access per 3 cycles.
- Zero-wait memory: exactly 1 cycle with `mem_en`=1.
- Timeout: ack/err asserted `TIMEOUT`+1 cycles after the grant edge; `mem_en` is high for exactly `TIMEOUT` cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum `{ARB_IDLE, ARB_ACCESS, ARB_DONE}`;
  - the owner constants `OWN_CPU`=0 and `OWN_AUX`=1;
  - the default `TIMEOUT`.
- Sub-module `arb_timeout`: a loadable up-counter with clear, enable, and a `hit` output at `TIMEOUT`. It is reused by the future UART loader.
- Round-robin pick stays inline.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with both req=1 → all outputs 0, no `mem_en`. First edge after release grants r0 (`owner`=0).
- r0 read at 0x0010, memory answers 0xBEEF with zero wait → `mem_en` for 1 cycle with `mem_addr`=0x0010 and `mem_we`=0 → `r0_ack`=1, `r0_err`=0, `r0_rdata`=0xBEEF two cycles after the request sample.
- Both req continuously high: r0 read 0x0001, r1 write 0x0002/0x1234 → grants alternate r0, r1, r0, r1. The r1 write shows `mem_we`=1 and `mem_wdata`=0x1234; `r1_rdata` is unchanged.
- Memory with 3 wait cycles: r1 read → `mem_en` high for 4 cycles with stable addr, then one `r1_ack`, then IDLE. Dropping `r1_req` mid-ACCESS still yields the ack.
- `TIMEOUT`=4, `mem_ready` stuck 0: r0 write → `mem_en` for 4 cycles, `r0_ack`=1 with `r0_err`=1, `mem_en`=0. The next request proceeds normally.
- `rst_n`=0 during the 2nd cycle of a waited access → next cycle in IDLE, `mem_en`=0, no ack ever pulses, `r0_rdata`=0.
